// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle tick every div clocks and a square wave that
// toggles on every tick. A divisor write is held in a per-channel shadow
// register and takes effect at the channel's next wrap, or at once on
// sync_clr, so a period is never cut short.
// Optional build macro TICK_GEN_STATUS_EN adds the debug readback ports
// pend_o (pending-write flags) and cnt_o (counter of channel div_sel).
module tick_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50_000_000,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
`ifdef TICK_GEN_STATUS_EN
  ,
  output logic [NUM_CH-1:0] pend_o,
  output logic [CNT_W-1:0]  cnt_o
`endif
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // A divisor of 0 would never wrap; it is treated as 1.
  logic [CNT_W-1:0] wr_val;
  assign wr_val = (div_val == '0) ? ONE : div_val;

`ifdef TICK_GEN_STATUS_EN
  logic [CNT_W-1:0] cnt_rb [NUM_CH];
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wr_hit;
    logic             wrap;

    // Out-of-range selects never match any channel, so such writes are dropped.
    assign wr_hit = div_we && (div_sel == SEL_W'(g));
    // cnt never exceeds div-1, because div only changes at a wrap or a clear.
    assign wrap   = (cnt_q == div_q - ONE);

    // Next-state: clear has priority, then counting, then shadow writes.
    always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      sq_d     = sq_q;
      if (sync_clr) begin
        cnt_d  = '0;
        sq_d   = 1'b0;
        pend_d = 1'b0;
        if (wr_hit) begin
          // A write in the clear cycle commits together with the clear.
          shadow_d = wr_val;
          div_d    = wr_val;
        end else if (pend_q) begin
          div_d = shadow_q;
        end
      end else begin
        if (en) begin
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (pend_q) begin
              div_d  = shadow_q;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        // A write on the wrap edge lands after the commit, so it waits a period.
        if (wr_hit) begin
          shadow_d = wr_val;
          pend_d   = 1'b1;
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shadow divisor is reset too, so a pending write never survives reset.
      if (!rst_n) begin
        cnt_q    <= '0;
        div_q    <= DEF_DIV;
        shadow_q <= DEF_DIV;
        pend_q   <= 1'b0;
        tick_q   <= 1'b0;
        sq_q     <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values.
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        tick_q   <= tick_d;
        sq_q     <= sq_d;
      end
    end

    assign tick[g] = tick_q;
    assign sq[g]   = sq_q;
`ifdef TICK_GEN_STATUS_EN
    assign pend_o[g] = pend_q;
    assign cnt_rb[g] = cnt_q;
`endif
  end

`ifdef TICK_GEN_STATUS_EN
  // Counter readback of the selected channel; reads 0 for an unused select.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (div_sel == SEL_W'(i)) cnt_o = cnt_rb[i];
    end
  end
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen with NUM_CH=2, CNT_W=8, DEFAULT_DIV=4.
// A table of per-edge stimulus and hand-derived outputs drives a scoreboard
// queue; reset behaviour and restart are covered by a hand-written sequence.
module tb_tick_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              sync_clr;
  logic              div_we;
  logic [0:0]        div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
`ifdef TICK_GEN_STATUS_EN
  logic [NUM_CH-1:0] pend_o;
  logic [CNT_W-1:0]  cnt_o;
`endif

  tick_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .div_we   (div_we),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .tick     (tick),
    .sq       (sq)
`ifdef TICK_GEN_STATUS_EN
    ,
    .pend_o   (pend_o),
    .cnt_o    (cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {en, sync_clr, div_we}; tick/sq/pend bit0 = channel 0.
  typedef struct {
    logic [2:0] ctrl;
    logic       sel;
    logic [7:0] val;
    logic [1:0] tick;
    logic [1:0] sq;
    logic [1:0] pend;
  } vec_t;

  typedef struct {
    logic [1:0] tick;
    logic [1:0] sq;
    logic [1:0] pend;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input logic [2:0] ctrl, input logic sel,
                             input logic [7:0] val, input logic [1:0] t,
                             input logic [1:0] s, input logic [1:0] p);
    vec_t r;
    r.ctrl = ctrl; r.sel = sel; r.val = val;
    r.tick = t; r.sq = s; r.pend = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one edge of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t x, input int id);
    exp_t e;
    @(negedge clk);
    {en, sync_clr, div_we} = x.ctrl;
    div_sel = x.sel;
    div_val = x.val;
    exp_q.push_back('{tick: x.tick, sq: x.sq, pend: x.pend, id: id});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("scoreboard empty e%0d", id), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("tick e%0d", e.id), 32'(tick), 32'(e.tick));
      check($sformatf("sq e%0d", e.id), 32'(sq), 32'(e.sq));
`ifdef TICK_GEN_STATUS_EN
      check($sformatf("pend e%0d", e.id), 32'(pend_o), 32'(e.pend));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // e1..e12: default div 4 on both channels; ch1 rewritten to 2 at e5.
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e1
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e2
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e3
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00)); // e4
    vecs.push_back(v(3'b101, 1'b1, 8'd2, 2'b00, 2'b11, 2'b10)); // e5 write ch1=2
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b11, 2'b10)); // e6
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b11, 2'b10)); // e7
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b00, 2'b00)); // e8 commit
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e9
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b10, 2'b00)); // e10
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b10, 2'b00)); // e11
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b01, 2'b00)); // e12
    // e13..e19: pause three cycles with ch0 cnt=2.
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b01, 2'b00)); // e13
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b11, 2'b00)); // e14
    vecs.push_back(v(3'b000, 1'b0, 8'd0, 2'b00, 2'b11, 2'b00)); // e15 en=0
    vecs.push_back(v(3'b000, 1'b0, 8'd0, 2'b00, 2'b11, 2'b00)); // e16
    vecs.push_back(v(3'b000, 1'b0, 8'd0, 2'b00, 2'b11, 2'b00)); // e17
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b11, 2'b00)); // e18
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b00, 2'b00)); // e19
    // e20..e28: sync_clr together with a write of 6 to ch0.
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e20
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b10, 2'b00)); // e21
    vecs.push_back(v(3'b111, 1'b0, 8'd6, 2'b00, 2'b00, 2'b00)); // e22 clr+write
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e23
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b10, 2'b00)); // e24
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b10, 2'b00)); // e25
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b00, 2'b00)); // e26
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e27
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00)); // e28 ch0 after 6
    // e29..e34: write 0 to ch0 (clamped to 1), then sync_clr.
    vecs.push_back(v(3'b101, 1'b0, 8'd0, 2'b00, 2'b11, 2'b01)); // e29
    vecs.push_back(v(3'b110, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00)); // e30 clr
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b01, 2'b01, 2'b00)); // e31
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b10, 2'b00)); // e32
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b01, 2'b11, 2'b00)); // e33
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b00, 2'b00)); // e34
    // e35..e36: write on a wrap edge stays pending for one more period.
    vecs.push_back(v(3'b101, 1'b0, 8'd3, 2'b01, 2'b01, 2'b01)); // e35
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b10, 2'b00)); // e36
    // e37..e42: second write before commit replaces the first.
    vecs.push_back(v(3'b101, 1'b0, 8'd5, 2'b00, 2'b10, 2'b01)); // e37
    vecs.push_back(v(3'b101, 1'b0, 8'd2, 2'b10, 2'b00, 2'b01)); // e38
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b01, 2'b01, 2'b00)); // e39
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b11, 2'b00)); // e40
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b01, 2'b10, 2'b00)); // e41
    vecs.push_back(v(3'b100, 1'b0, 8'd0, 2'b10, 2'b00, 2'b00)); // e42
    // e43: leave a pending write on ch1 just before reset.
    vecs.push_back(v(3'b101, 1'b1, 8'd7, 2'b01, 2'b01, 2'b10)); // e43

    rst_n    = 1'b0;
    en       = 1'b0;
    sync_clr = 1'b0;
    div_we   = 1'b0;
    div_sel  = 1'b0;
    div_val  = '0;
    #3;
    check("reset tick", 32'(tick), 32'd0);
    check("reset sq", 32'(sq), 32'd0);
`ifdef TICK_GEN_STATUS_EN
    check("reset pend", 32'(pend_o), 32'd0);
    check("reset cnt_o", 32'(cnt_o), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i + 1);
    end

    // Asynchronous reset between edges while tick and sq are high.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst tick", 32'(tick), 32'd0);
    check("async rst sq", 32'(sq), 32'd0);
`ifdef TICK_GEN_STATUS_EN
    check("async rst pend", 32'(pend_o), 32'd0);
`endif
    rst_n = 1'b1;

    // Restart from 0 with the default divisor on both channels.
    step(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00), 101);
    step(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00), 102);
`ifdef TICK_GEN_STATUS_EN
    check("cnt_o ch0 after 2 edges", 32'(cnt_o), 32'd2);
`endif
    step(v(3'b100, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00), 103);
    step(v(3'b100, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00), 104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
